// File: rtl/imager_pkg.sv
// Shared definitions for the imager readout path: state encodings, status codes,
// parameter defaults and the configuration shadow type.
package imager_pkg;

  localparam int DEF_NUM_ROWS    = 160;
  localparam int DEF_ROW_SETTLE  = 4;
  localparam int DEF_ADC_TIMEOUT = 255;

  localparam logic [6:0] S_IDLE   = 7'b0000001;
  localparam logic [6:0] S_REQ    = 7'b0000010;
  localparam logic [6:0] S_EXPOSE = 7'b0000100;
  localparam logic [6:0] S_SETTLE = 7'b0001000;
  localparam logic [6:0] S_CONV   = 7'b0010000;
  localparam logic [6:0] S_NEXT   = 7'b0100000;
  localparam logic [6:0] S_ACK    = 7'b1000000;

  // seq_stat groups the seven states into four one-hot phases
  localparam logic [3:0] STAT_IDLE     = 4'b0001;
  localparam logic [3:0] STAT_EXPOSURE = 4'b0010;
  localparam logic [3:0] STAT_READOUT  = 4'b0100;
  localparam logic [3:0] STAT_ACK      = 4'b1000;

  typedef struct packed {
    logic [31:0] exp_subc;
    logic [31:0] num_pat;
  } shadow_cfg_t;

  localparam shadow_cfg_t CFG_RESET = '{exp_subc: 32'd0, num_pat: 32'd1};

  // A zero pattern count is meaningless downstream, so it is promoted to one.
  function automatic shadow_cfg_t capture_cfg(input logic [31:0] exp_in,
                                              input logic [31:0] pat_in);
    shadow_cfg_t cfg;
    cfg.exp_subc = exp_in;
    cfg.num_pat  = (pat_in == 32'd0) ? 32'd1 : pat_in;
    return cfg;
  endfunction

endpackage

// File: rtl/row_timer.sv
// Per-row cycle timer: restarted on entry to SETTLE and CONV, it flags the end of
// the settle interval and the ADC-done timeout.
module row_timer
  import imager_pkg::*;
#(
  parameter int C_ROW_SETTLE  = DEF_ROW_SETTLE,
  parameter int C_ADC_TIMEOUT = DEF_ADC_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic settle_done_o,
  output logic timeout_o
);

  localparam int MAX_CNT = (C_ADC_TIMEOUT > C_ROW_SETTLE) ? C_ADC_TIMEOUT : C_ROW_SETTLE;
  localparam int CW      = $clog2(MAX_CNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates so a long stall in another state can never alias a terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(MAX_CNT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign settle_done_o = (cnt_q == CW'(C_ROW_SETTLE));
  assign timeout_o     = (cnt_q == CW'(C_ADC_TIMEOUT - 1));

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: hands frames to the exposure FSM, then walks every pixel row
// through settle and ADC conversion before acknowledging the readout.
module frame_sequencer
  import imager_pkg::*;
#(
  parameter int C_NUM_ROWS    = DEF_NUM_ROWS,
  parameter int C_ROW_SETTLE  = DEF_ROW_SETTLE,
  parameter int C_ADC_TIMEOUT = DEF_ADC_TIMEOUT
) (
  input  logic        CLKMPRE,
  input  logic        RESET_B,
  input  logic        ARM,
  input  logic        STOP,
  input  logic [15:0] NUM_FRAMES,
  input  logic [31:0] EXP_SUBC_IN,
  input  logic [31:0] NUM_PAT_IN,
  output logic [31:0] Exp_subc,
  output logic [31:0] Num_Pat,
  output logic        FSMIND0,
  input  logic        FSMIND0ACK,
  input  logic        FSMIND1,
  output logic        FSMIND1ACK,
  output logic [7:0]  ROW_ADDR,
  output logic        ADC_CONV,
  input  logic        ADC_DONE,
  output logic [15:0] FRAME_CNT,
  output logic        BUSY,
  output logic        ERR,
  output logic [3:0]  seq_stat
);

  localparam logic [7:0] LAST_ROW = 8'(C_NUM_ROWS - 1);

  logic [6:0]  state_q, state_d;
  shadow_cfg_t cfg_q, cfg_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_q, err_d;
  logic        adc_conv_q, adc_conv_d;
  logic        timer_clear, settle_done, conv_timeout;

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        cfg_d = capture_cfg(EXP_SUBC_IN, NUM_PAT_IN);
        if (!ARM) begin
          err_d = 1'b0;
        end else if (!err_q) begin
          frame_cnt_d = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ:    if (FSMIND0ACK) state_d = S_EXPOSE;
      S_EXPOSE: begin
        if (FSMIND1) begin
          row_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: if (settle_done) state_d = S_CONV;
      S_CONV: begin
        if (ADC_DONE) begin
          state_d = S_NEXT;
        end else if (conv_timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        if (row_q < LAST_ROW) begin
          row_d   = row_q + 8'd1;
          state_d = S_SETTLE;
        end else begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        // STOP is only honoured here, so a started frame always completes
        if (!FSMIND1) begin
          if (STOP || (NUM_FRAMES != 16'd0 && frame_cnt_q == NUM_FRAMES)) begin
            state_d = S_IDLE;
          end else begin
            cfg_d   = capture_cfg(EXP_SUBC_IN, NUM_PAT_IN);
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign timer_clear = ((state_d == S_SETTLE) && (state_q != S_SETTLE)) ||
                       ((state_d == S_CONV) && (state_q != S_CONV));
  assign adc_conv_d  = (state_d == S_CONV) && (state_q != S_CONV);

  always_ff @(posedge CLKMPRE or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q     <= S_IDLE;
      cfg_q       <= CFG_RESET;
      row_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      adc_conv_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      row_q       <= row_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      adc_conv_q  <= adc_conv_d;
    end
  end

  row_timer #(
    .C_ROW_SETTLE (C_ROW_SETTLE),
    .C_ADC_TIMEOUT(C_ADC_TIMEOUT)
  ) u_row_timer (
    .clk_i        (CLKMPRE),
    .rst_n_i      (RESET_B),
    .clear_i      (timer_clear),
    .settle_done_o(settle_done),
    .timeout_o    (conv_timeout)
  );

  always_comb begin
    seq_stat = STAT_IDLE;
    case (state_q)
      S_REQ, S_EXPOSE:          seq_stat = STAT_EXPOSURE;
      S_SETTLE, S_CONV, S_NEXT: seq_stat = STAT_READOUT;
      S_ACK:                    seq_stat = STAT_ACK;
      default:                  seq_stat = STAT_IDLE;
    endcase
  end

  assign FSMIND0    = (state_q == S_REQ);
  assign FSMIND1ACK = (state_q == S_ACK);
  assign BUSY       = (state_q != S_IDLE);
  assign ADC_CONV   = adc_conv_q;
  assign ROW_ADDR   = row_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign ERR        = err_q;
  assign Exp_subc   = cfg_q.exp_subc;
  assign Num_Pat    = cfg_q.num_pat;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with behavioural exposure-FSM and ADC models.
module tb_frame_sequencer;

  logic        CLKMPRE = 1'b0;
  logic        RESET_B;
  logic        ARM, STOP;
  logic [15:0] NUM_FRAMES;
  logic [31:0] EXP_SUBC_IN, NUM_PAT_IN;
  logic [31:0] Exp_subc, Num_Pat;
  logic        FSMIND0, FSMIND0ACK, FSMIND1, FSMIND1ACK;
  logic [7:0]  ROW_ADDR;
  logic        ADC_CONV, ADC_DONE;
  logic [15:0] FRAME_CNT;
  logic        BUSY, ERR;
  logic [3:0]  seq_stat;

  frame_sequencer dut (
    .CLKMPRE    (CLKMPRE),
    .RESET_B    (RESET_B),
    .ARM        (ARM),
    .STOP       (STOP),
    .NUM_FRAMES (NUM_FRAMES),
    .EXP_SUBC_IN(EXP_SUBC_IN),
    .NUM_PAT_IN (NUM_PAT_IN),
    .Exp_subc   (Exp_subc),
    .Num_Pat    (Num_Pat),
    .FSMIND0    (FSMIND0),
    .FSMIND0ACK (FSMIND0ACK),
    .FSMIND1    (FSMIND1),
    .FSMIND1ACK (FSMIND1ACK),
    .ROW_ADDR   (ROW_ADDR),
    .ADC_CONV   (ADC_CONV),
    .ADC_DONE   (ADC_DONE),
    .FRAME_CNT  (FRAME_CNT),
    .BUSY       (BUSY),
    .ERR        (ERR),
    .seq_stat   (seq_stat)
  );

  always #5 CLKMPRE = ~CLKMPRE;

  int cyc = 0;
  always @(posedge CLKMPRE) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // model knobs
  int ack_delay, expose_len, hold_len;
  logic hang_en;
  logic [7:0] hang_row;

  // statistics gathered by the monitor
  int conv_cnt, row_err, exp_row, last_conv_cyc, err_cyc;
  int f1_cyc, first_conv_lat, ind0_rises, ind0_cycles, ack1_rises, ack1_cycles, fcnt_glitch;
  logic first_conv_pending, prev_ind0, prev_ack1, prev_err;
  logic [15:0] prev_fcnt;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLKMPRE);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic clear_stats();
    conv_cnt = 0; row_err = 0; exp_row = 0; last_conv_cyc = 0; err_cyc = 0;
    first_conv_lat = -1; ind0_rises = 0; ind0_cycles = 0;
    ack1_rises = 0; ack1_cycles = 0; fcnt_glitch = 0;
  endtask

  task automatic pulse_arm();
    ARM = 1'b1;
    step(1);
    ARM = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (BUSY && n < budget) begin
      step(1);
      n++;
    end
    check_eq({tag, "_idle_reached"}, BUSY, 1'b0);
  endtask

  // ADC: answers three cycles after each pulse unless the hang row is selected
  initial begin
    int pend = 0;
    ADC_DONE = 1'b0;
    forever begin
      @(posedge CLKMPRE);
      #1;
      ADC_DONE = 1'b0;
      if (!RESET_B) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) ADC_DONE = 1'b1;
        end
        if (ADC_CONV && !(hang_en && ROW_ADDR == hang_row)) pend = 3;
      end
    end
  end

  // Exposure FSM model
  initial begin
    int ex_st = 0;
    int ex_cnt = 0;
    FSMIND0ACK = 1'b0;
    FSMIND1 = 1'b0;
    forever begin
      @(posedge CLKMPRE);
      #1;
      if (!RESET_B || !BUSY) begin
        ex_st = 0;
        FSMIND0ACK = 1'b0;
        FSMIND1 = 1'b0;
      end else begin
        case (ex_st)
          0: if (FSMIND0) begin
               if (ack_delay == 0) begin
                 FSMIND0ACK = 1'b1; ex_st = 2; ex_cnt = expose_len;
               end else begin
                 ex_cnt = ack_delay - 1; ex_st = 1;
               end
             end
          1: if (ex_cnt == 0) begin
               FSMIND0ACK = 1'b1; ex_st = 2; ex_cnt = expose_len;
             end else ex_cnt--;
          2: begin
               FSMIND0ACK = 1'b0;
               if (ex_cnt == 0) begin
                 FSMIND1 = 1'b1; ex_st = 3;
                 f1_cyc = cyc; first_conv_pending = 1'b1;
               end else ex_cnt--;
             end
          3: if (FSMIND1ACK) begin
               if (hold_len == 0) begin
                 FSMIND1 = 1'b0; ex_st = 0;
               end else begin
                 ex_cnt = hold_len - 1; ex_st = 4;
               end
             end
          default: if (ex_cnt == 0) begin
               FSMIND1 = 1'b0; ex_st = 0;
             end else ex_cnt--;
        endcase
      end
    end
  end

  // Monitor samples on the falling edge
  initial begin
    first_conv_pending = 1'b0;
    prev_ind0 = 1'b0; prev_ack1 = 1'b0; prev_err = 1'b0; prev_fcnt = '0;
    forever begin
      @(negedge CLKMPRE);
      if (ADC_CONV) begin
        conv_cnt++;
        if (int'(ROW_ADDR) != exp_row) row_err++;
        exp_row = (exp_row == 159) ? 0 : exp_row + 1;
        last_conv_cyc = cyc;
        if (first_conv_pending) begin
          first_conv_lat = cyc - f1_cyc;
          first_conv_pending = 1'b0;
        end
      end
      if (FSMIND0) ind0_cycles++;
      if (FSMIND0 && !prev_ind0) ind0_rises++;
      if (FSMIND1ACK) ack1_cycles++;
      if (FSMIND1ACK && !prev_ack1) begin
        ack1_rises++;
        if (FRAME_CNT != prev_fcnt + 16'd1) fcnt_glitch++;
      end
      if (FSMIND1ACK && prev_ack1 && FRAME_CNT != prev_fcnt) fcnt_glitch++;
      if (ERR && !prev_err) err_cyc = cyc;
      prev_ind0 = FSMIND0; prev_ack1 = FSMIND1ACK; prev_err = ERR; prev_fcnt = FRAME_CNT;
    end
  end

  initial begin
    int n;
    RESET_B = 1'b0; ARM = 1'b0; STOP = 1'b0; NUM_FRAMES = 16'd0;
    EXP_SUBC_IN = 32'd7; NUM_PAT_IN = 32'd5;
    ack_delay = 2; expose_len = 5; hold_len = 0; hang_en = 1'b0; hang_row = 8'd0;
    clear_stats();
    step(3);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_fsmind0", FSMIND0, 0);
    check_eq("rst_fsmind1ack", FSMIND1ACK, 0);
    check_eq("rst_adc_conv", ADC_CONV, 0);
    check_eq("rst_row_addr", ROW_ADDR, 0);
    check_eq("rst_frame_cnt", FRAME_CNT, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_exp_subc", Exp_subc, 0);
    check_eq("rst_num_pat", Num_Pat, 1);
    check_eq("rst_seq_stat", seq_stat, 4'b0001);

    RESET_B = 1'b1;
    step(2);
    check_eq("idle_track_exp", Exp_subc, 7);
    check_eq("idle_track_pat", Num_Pat, 5);

    // Case 1: two frames, full readout
    NUM_FRAMES = 16'd2; EXP_SUBC_IN = 32'd20; NUM_PAT_IN = 32'd9;
    clear_stats();
    pulse_arm();
    check_eq("c1_fsmind0_latency", FSMIND0, 1);
    check_eq("c1_busy", BUSY, 1);
    check_eq("c1_stat_exposure", seq_stat, 4'b0010);
    check_eq("c1_exp_subc", Exp_subc, 20);
    check_eq("c1_num_pat", Num_Pat, 9);
    wait_idle(8000, "c1");
    check_eq("c1_conv_pulses", conv_cnt, 320);
    check_eq("c1_row_seq_err", row_err, 0);
    check_eq("c1_frame_cnt", FRAME_CNT, 2);
    check_eq("c1_fsmind0_frames", ind0_rises, 2);
    check_eq("c1_ack_frames", ack1_rises, 2);
    check_eq("c1_fsmind1_to_conv", first_conv_lat, 6);
    check_eq("c1_fcnt_once", fcnt_glitch, 0);
    check_eq("c1_err", ERR, 0);
    check_eq("c1_stat_idle", seq_stat, 4'b0001);

    // Case 4: shadow configuration
    NUM_FRAMES = 16'd2; EXP_SUBC_IN = 32'd10; NUM_PAT_IN = 32'd0;
    clear_stats();
    pulse_arm();
    n = 0;
    while (!(BUSY && !FSMIND0 && seq_stat == 4'b0010) && n < 200) begin step(1); n++; end
    check_eq("c4_expose_reached", n < 200, 1);
    EXP_SUBC_IN = 32'd50;
    step(3);
    check_eq("c4_exp_held", Exp_subc, 10);
    check_eq("c4_num_pat_zero", Num_Pat, 1);
    n = 0;
    while (!FSMIND0 && n < 4000) begin step(1); n++; end
    check_eq("c4_second_req", ack1_rises, 1);
    check_eq("c4_exp_reloaded", Exp_subc, 50);
    wait_idle(4000, "c4");
    check_eq("c4_frame_cnt", FRAME_CNT, 2);

    // Case 2: ADC never answers on row 37
    NUM_FRAMES = 16'd1; hang_en = 1'b1; hang_row = 8'd37;
    clear_stats();
    ARM = 1'b1;
    n = 0;
    while (!ERR && n < 3000) begin step(1); n++; end
    check_eq("c2_err_set", ERR, 1);
    check_eq("c2_idle_entered", BUSY, 0);
    step(5);
    check_eq("c2_timeout_cycles", err_cyc - last_conv_cyc, 255);
    check_eq("c2_conv_pulses", conv_cnt, 38);
    check_eq("c2_no_fsmind1ack", ack1_rises, 0);
    check_eq("c2_arm_blocked", BUSY, 0);
    check_eq("c2_err_sticky", ERR, 1);
    check_eq("c2_single_req", ind0_rises, 1);
    ARM = 1'b0;
    step(1);
    check_eq("c2_err_cleared", ERR, 0);
    hang_en = 1'b0;

    // Case 3: free-running, STOP during row 80 of frame 3
    NUM_FRAMES = 16'd0;
    clear_stats();
    pulse_arm();
    n = 0;
    while (!(FRAME_CNT == 16'd2 && ROW_ADDR == 8'd80) && n < 6000) begin step(1); n++; end
    check_eq("c3_row80_reached", n < 6000, 1);
    STOP = 1'b1;
    wait_idle(3000, "c3");
    STOP = 1'b0;
    step(20);
    check_eq("c3_frame_cnt", FRAME_CNT, 3);
    check_eq("c3_conv_pulses", conv_cnt, 480);
    check_eq("c3_no_extra_req", ind0_rises, 3);
    check_eq("c3_ack_frames", ack1_rises, 3);
    check_eq("c3_stays_idle", BUSY, 0);

    // Case 6: slow handshakes
    ack_delay = 100; hold_len = 20; NUM_FRAMES = 16'd2;
    clear_stats();
    pulse_arm();
    wait_idle(8000, "c6");
    check_eq("c6_fsmind0_held", ind0_cycles, 202);
    check_eq("c6_fsmind1ack_held", ack1_cycles, 42);
    check_eq("c6_frame_cnt", FRAME_CNT, 2);
    check_eq("c6_fcnt_once", fcnt_glitch, 0);
    check_eq("c6_fsmind1_to_conv", first_conv_lat, 6);
    ack_delay = 2; hold_len = 0;

    // Case 5: asynchronous reset during CONV of row 12 in frame 2
    NUM_FRAMES = 16'd2; EXP_SUBC_IN = 32'd33; NUM_PAT_IN = 32'd4;
    clear_stats();
    pulse_arm();
    n = 0;
    while (!(ADC_CONV && ROW_ADDR == 8'd12 && FRAME_CNT == 16'd1) && n < 4000) begin step(1); n++; end
    check_eq("c5_row12_reached", n < 4000, 1);
    #2 RESET_B = 1'b0;
    #1;
    check_eq("c5_adc_conv", ADC_CONV, 0);
    check_eq("c5_busy", BUSY, 0);
    check_eq("c5_row_addr", ROW_ADDR, 0);
    check_eq("c5_frame_cnt", FRAME_CNT, 0);
    check_eq("c5_exp_subc", Exp_subc, 0);
    check_eq("c5_num_pat", Num_Pat, 1);
    check_eq("c5_seq_stat", seq_stat, 4'b0001);
    check_eq("c5_fsmind0", FSMIND0, 0);
    check_eq("c5_fsmind1ack", FSMIND1ACK, 0);
    @(posedge CLKMPRE);
    #1;
    RESET_B = 1'b1;
    step(5);
    NUM_FRAMES = 16'd1;
    clear_stats();
    pulse_arm();
    wait_idle(3000, "c5r");
    check_eq("c5r_conv_pulses", conv_cnt, 160);
    check_eq("c5r_row_seq_err", row_err, 0);
    check_eq("c5r_frame_cnt", FRAME_CNT, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
